// File: rtl/dmac_pkg.sv
// Shared constants, register map and FSM state type for the ahbl_dmac
// single-channel AHB-Lite DMA controller.
package dmac_pkg;

  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_CNT    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_START   = 0;
  localparam int CTRL_SRC_INC = 1;
  localparam int CTRL_DST_INC = 2;
  localparam int CTRL_SIZE_LO = 3;
  localparam int CTRL_IRQ_EN  = 5;
  localparam int CTRL_HW_REQ  = 6;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAITREQ = 3'd1,
    S_RADDR   = 3'd2,
    S_RDATA   = 3'd3,
    S_WADDR   = 3'd4,
    S_WDATA   = 3'd5,
    S_DONE    = 3'd6
  } dmac_state_e;

  function automatic logic [2:0] size_to_hsize(input logic [1:0] sz);
    return sz[1] ? 3'b010 : {2'b00, sz[0]};
  endfunction

  function automatic logic [31:0] size_to_inc(input logic [1:0] sz);
    return sz[1] ? 32'd4 : (sz[0] ? 32'd2 : 32'd1);
  endfunction

  // Pick the addressed lane of the read word and copy it onto every write lane.
  function automatic logic [31:0] lane_replicate(input logic [31:0] rd,
                                                 input logic [1:0] a,
                                                 input logic [1:0] sz);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      SIZE_BYTE: return {4{b}};
      SIZE_HALF: return {2{h}};
      default:   return rd;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_dmac_if.sv
// AHB-Lite slave (register) and master (engine) signal bundle for ahbl_dmac.
// DREQ exists only when DMAC_HWREQ_EN is defined.
interface ahbl_dmac_if;
  import dmac_pkg::*;

  // Both sides follow AHB-Lite: an address phase is accepted on the clock edge
  // where HTRANS[1] and HREADY are both high; its data phase then lasts until
  // the first edge with HREADY high, and address/control must not change while
  // the current phase is stalled.
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  logic [31:0] M_HADDR;
  logic [1:0]  M_HTRANS;
  logic [2:0]  M_HSIZE;
  logic [2:0]  M_HBURST;
  logic        M_HWRITE;
  logic [31:0] M_HWDATA;
  logic        M_HREADY;
  logic [31:0] M_HRDATA;

  logic        IRQ;
`ifdef DMAC_HWREQ_EN
  logic        DREQ;
`endif
  dmac_state_e dbg_state;

  modport slave (
`ifdef DMAC_HWREQ_EN
    input  DREQ,
`endif
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA, M_HREADY, M_HRDATA,
    output HREADYOUT, HRDATA, M_HADDR, M_HTRANS, M_HSIZE, M_HBURST, M_HWRITE,
           M_HWDATA, IRQ, dbg_state
  );

  modport master (
`ifdef DMAC_HWREQ_EN
    output DREQ,
`endif
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA, M_HREADY, M_HRDATA,
    input  HREADYOUT, HRDATA, M_HADDR, M_HTRANS, M_HSIZE, M_HBURST, M_HWRITE,
           M_HWDATA, IRQ, dbg_state
  );
endinterface

// File: rtl/dmac_regs.sv
// Zero-wait AHB-Lite register file for ahbl_dmac: config registers, start pulse,
// sticky done with W1C. CTRL[6] hw_req is only storable with DMAC_HWREQ_EN.
module dmac_regs import dmac_pkg::*; #(
  parameter int          W_CNT   = 16,
  parameter logic [31:0] RST_SRC = 32'h2000_0000,
  parameter logic [31:0] RST_DST = 32'h2000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsel,
  input  logic [31:0]      haddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic             hready,
  input  logic [31:0]      hwdata,
  output logic [31:0]      hrdata,
  input  logic             busy,
  input  logic             set_done,
  output logic             start,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [W_CNT-1:0] cnt,
  output logic             src_inc,
  output logic             dst_inc,
  output logic [1:0]       size,
  output logic             hw_req,
  output logic             irq
);

`ifdef DMAC_HWREQ_EN
  localparam logic HW_REQ_IMPL = 1'b1;
`else
  localparam logic HW_REQ_IMPL = 1'b0;
`endif

  logic       wr_pend;
  logic [2:0] addr_q;
  logic [6:1] ctrl_q;
  logic       done;
  logic       cfg_we;
  logic       unused_addr;

  assign unused_addr = ^{haddr[31:5], haddr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= 1'b0;
      addr_q  <= '0;
    end else if (hsel && hready && htrans[1]) begin
      wr_pend <= hwrite;
      addr_q  <= haddr[4:2];
    end else begin
      wr_pend <= 1'b0;
    end
  end

  // Configuration is frozen while the engine owns the working copies.
  assign cfg_we = wr_pend && !busy;
  assign start  = cfg_we && (addr_q == REG_CTRL) && hwdata[CTRL_START];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src    <= RST_SRC;
      dst    <= RST_DST;
      cnt    <= '0;
      ctrl_q <= '0;
      done   <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (addr_q)
          REG_SRC:  src    <= hwdata;
          REG_DST:  dst    <= hwdata;
          REG_CNT:  cnt    <= hwdata[W_CNT-1:0];
          REG_CTRL: ctrl_q <= {hwdata[CTRL_HW_REQ] & HW_REQ_IMPL, hwdata[5:1]};
          default: ;
        endcase
      end
      if (set_done)
        done <= 1'b1;
      else if (wr_pend && (addr_q == REG_STATUS) && hwdata[1])
        done <= 1'b0;
    end
  end

  always_comb begin
    hrdata = '0;
    case (addr_q)
      REG_SRC:    hrdata = src;
      REG_DST:    hrdata = dst;
      REG_CNT:    hrdata[W_CNT-1:0] = cnt;
      REG_CTRL:   hrdata[6:0] = {ctrl_q, 1'b0};
      REG_STATUS: hrdata[1:0] = {done, busy};
      default:    hrdata = '0;
    endcase
  end

  assign src_inc = ctrl_q[CTRL_SRC_INC];
  assign dst_inc = ctrl_q[CTRL_DST_INC];
  assign size    = ctrl_q[CTRL_SIZE_LO+1:CTRL_SIZE_LO];
  assign hw_req  = ctrl_q[CTRL_HW_REQ];
  assign irq     = done & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/ahbl_dmac.sv
// Single-channel AHB-Lite DMA: read-then-write SINGLE transfers until the count
// is exhausted. DMAC_HWREQ_EN adds DREQ pacing through the WAITREQ state.
module ahbl_dmac import dmac_pkg::*; #(
  parameter int          W_CNT   = 16,
  parameter logic [31:0] RST_SRC = 32'h2000_0000,
  parameter logic [31:0] RST_DST = 32'h2000_0000
) (
  input logic        HCLK,
  input logic        HRESETn,
  ahbl_dmac_if.slave bus
);

  dmac_state_e      state, state_nxt, first_state;
  logic             start, src_inc, dst_inc, hw_req;
  logic [1:0]       size;
  logic [31:0]      src, dst, src_w, dst_w, wbuf, inc;
  logic [W_CNT-1:0] cnt, cnt_w;
  logic             unused_hsize;

  assign unused_hsize = ^bus.HSIZE;

  dmac_regs #(.W_CNT(W_CNT), .RST_SRC(RST_SRC), .RST_DST(RST_DST)) u_regs (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .hsel     (bus.HSEL),
    .haddr    (bus.HADDR),
    .htrans   (bus.HTRANS),
    .hwrite   (bus.HWRITE),
    .hready   (bus.HREADY),
    .hwdata   (bus.HWDATA),
    .hrdata   (bus.HRDATA),
    .busy     (state != S_IDLE),
    .set_done (state == S_DONE),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .cnt      (cnt),
    .src_inc  (src_inc),
    .dst_inc  (dst_inc),
    .size     (size),
    .hw_req   (hw_req),
    .irq      (bus.IRQ)
  );

  assign inc         = size_to_inc(size);
  assign first_state = hw_req ? S_WAITREQ : S_RADDR;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (cnt == '0) ? S_DONE : first_state;
`ifdef DMAC_HWREQ_EN
      S_WAITREQ: if (bus.DREQ) state_nxt = S_RADDR;
`else
      S_WAITREQ: state_nxt = S_RADDR;
`endif
      S_RADDR:   if (bus.M_HREADY) state_nxt = S_RDATA;
      S_RDATA:   if (bus.M_HREADY) state_nxt = S_WADDR;
      S_WADDR:   if (bus.M_HREADY) state_nxt = S_WDATA;
      S_WDATA:   if (bus.M_HREADY) state_nxt = (cnt_w == W_CNT'(1)) ? S_DONE : first_state;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_w <= '0;
      dst_w <= '0;
      cnt_w <= '0;
      wbuf  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          src_w <= src;
          dst_w <= dst;
          cnt_w <= cnt;
        end
        S_RDATA: if (bus.M_HREADY) wbuf <= lane_replicate(bus.M_HRDATA, src_w[1:0], size);
        S_WDATA: if (bus.M_HREADY) begin
          cnt_w <= cnt_w - W_CNT'(1);
          if (src_inc) src_w <= src_w + inc;
          if (dst_inc) dst_w <= dst_w + inc;
        end
        default: ;
      endcase
    end
  end

  // Address/control derive only from state and working registers, so they
  // hold still for as long as M_HREADY stalls a phase.
  always_comb begin
    bus.M_HTRANS = HTRANS_IDLE;
    bus.M_HADDR  = '0;
    bus.M_HWRITE = 1'b0;
    bus.M_HSIZE  = '0;
    case (state)
      S_RADDR, S_RDATA: begin
        bus.M_HTRANS = (state == S_RADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus.M_HADDR  = src_w;
        bus.M_HSIZE  = size_to_hsize(size);
      end
      S_WADDR, S_WDATA: begin
        bus.M_HTRANS = (state == S_WADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus.M_HADDR  = dst_w;
        bus.M_HWRITE = 1'b1;
        bus.M_HSIZE  = size_to_hsize(size);
      end
      default: ;
    endcase
  end

  assign bus.M_HWDATA  = wbuf;
  assign bus.M_HBURST  = 3'b000;
  assign bus.HREADYOUT = 1'b1;
  assign bus.dbg_state = state;

endmodule
